// File: rtl/hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_controller_pkg
// Shared types and encodings for the pipeline hazard controller.
//   hz_state_t      : sequencing FSM state (RUN / MC_WAIT)
//   FWD_*           : operand-forward select encodings seen by the EX muxes
//   RES_*           : ResultSrc encodings (RES_MEM marks a load)
//   raw_hit()       : true when a writing stage targets the given source reg
// ---------------------------------------------------------------------------
package hazard_controller_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } hz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // x0 is hard-wired to zero, so it never produces a dependency.
   function automatic logic raw_hit(input logic [4:0] rd,
                                    input logic       wr_en,
                                    input logic [4:0] rs);
      return wr_en && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_controller_forward_sel.sv
// ---------------------------------------------------------------------------
// hazard_forward_sel
// Forward-select comparison for one execute-stage source operand.
//   rs           in  5  source register of the operand in EX
//   rd_m         in  5  destination of the instruction in MEM
//   reg_write_m  in  1  MEM instruction writes the register file
//   rd_w         in  5  destination of the instruction in WB
//   reg_write_w  in  1  WB instruction writes the register file
//   fwd          out 2  FWD_MEM / FWD_WB / FWD_RF
// MEM wins over WB because it holds the younger (more recent) value.
// ---------------------------------------------------------------------------
module hazard_forward_sel
   import hazard_controller_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic       reg_write_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   always_comb begin
      if (raw_hit(rd_m, reg_write_m, rs)) begin
         fwd = FWD_MEM;
      end else if (raw_hit(rd_w, reg_write_w, rs)) begin
         fwd = FWD_WB;
      end else begin
         fwd = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Stall/flush/forward sequencing for the five-stage RV64I/Zba pipeline.
// Build option: define HAZARD_FWD_EN to enable operand forwarding; without
// it, every RAW dependency in decode stalls until the producer has retired.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   Rs1_D, Rs2_D                     decode-stage source registers
//   Rs1_E, Rs2_E                     execute-stage source registers
//   Rd_E, Rd_M, Rd_W                 destinations in EX / MEM / WB
//   RegWrite_E/_M/_W                 register-write enables per stage
//   ResultSrc_E                      EX result select (RES_MEM = load)
//   PCSrc_E                          taken branch / jump resolved in EX
//   MulDiv_E                         EX instruction uses the multi-cycle unit
//   McDone                           multi-cycle result valid (1-cycle pulse)
//   StallF, StallD, StallE           hold PC, IF/ID, ID/EX
//   FlushD, FlushE, FlushM           bubble into IF/ID, ID/EX, EX/MEM
//   McStart                          start pulse to the multi-cycle unit
//   ForwardA_E, ForwardB_E           EX operand source select
//   StallCount                       saturating count of StallF cycles
// Stall/flush/forward outputs are combinational; only the FSM state and the
// stall counter are registered.
// ---------------------------------------------------------------------------
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       Rs1_E,
   input  logic [4:0]       Rs2_E,
   input  logic [4:0]       Rd_E,
   input  logic [4:0]       Rd_M,
   input  logic [4:0]       Rd_W,
   input  logic             RegWrite_E,
   input  logic             RegWrite_M,
   input  logic             RegWrite_W,
   input  logic [1:0]       ResultSrc_E,
   input  logic             PCSrc_E,
   input  logic             MulDiv_E,
   input  logic             McDone,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic             McStart,
   output logic [1:0]       ForwardA_E,
   output logic [1:0]       ForwardB_E,
   output logic [CNT_W-1:0] StallCount
);

   hz_state_t        state_reg;
   logic [CNT_W-1:0] count_reg;

   logic             load_use;
   logic             d_hazard;
   logic             unused_ok;
   logic             stall_f, stall_d, stall_e;
   logic             flush_d, flush_e, flush_m;
   logic             mc_start;
   logic [1:0][4:0]  rs_e;
   logic [1:0][1:0]  fwd_sel;
   logic [1:0]       fwd_a, fwd_b;

   // ---------------- forwarding comparators, one per EX operand ----------
   assign rs_e[0] = Rs1_E;
   assign rs_e[1] = Rs2_E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         hazard_forward_sel u_sel (
            .rs          (rs_e[gi]),
            .rd_m        (Rd_M),
            .reg_write_m (RegWrite_M),
            .rd_w        (Rd_W),
            .reg_write_w (RegWrite_W),
            .fwd         (fwd_sel[gi])
         );
      end
   endgenerate

   // A load's data only exists after MEM, so a dependent instruction in
   // decode must wait one slot even with forwarding.
   assign load_use = (ResultSrc_E == RES_MEM) && (Rd_E != 5'd0) &&
                     ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

`ifdef HAZARD_FWD_EN
   assign d_hazard  = load_use;
   assign fwd_a     = fwd_sel[0];
   assign fwd_b     = fwd_sel[1];
   assign unused_ok = RegWrite_E;
`else
   // No bypass network: any in-flight writer of a decode source blocks
   // decode until it has left WB. This also covers the load case.
   assign d_hazard  = raw_hit(Rd_E, RegWrite_E, Rs1_D) | raw_hit(Rd_E, RegWrite_E, Rs2_D) |
                      raw_hit(Rd_M, RegWrite_M, Rs1_D) | raw_hit(Rd_M, RegWrite_M, Rs2_D) |
                      raw_hit(Rd_W, RegWrite_W, Rs1_D) | raw_hit(Rd_W, RegWrite_W, Rs2_D);
   assign fwd_a     = FWD_RF;
   assign fwd_b     = FWD_RF;
   assign unused_ok = ^{fwd_sel, load_use};
`endif

   // ---------------- stall / flush decisions -----------------------------
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      mc_start = 1'b0;
      if (!rst) begin
         case (state_reg)
            RUN: begin
               if (MulDiv_E) begin
                  // Freeze the front of the pipe and bubble MEM while the
                  // unit works; the start pulse goes out this same cycle.
                  mc_start = 1'b1;
                  stall_f  = 1'b1;
                  stall_d  = 1'b1;
                  stall_e  = 1'b1;
                  flush_m  = 1'b1;
               end else if (PCSrc_E) begin
                  // Redirect wins: the PC must load the target, so no stall.
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (d_hazard) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end
            MC_WAIT: begin
               stall_f = !McDone;
               stall_d = !McDone;
               stall_e = !McDone;
               flush_m = !McDone;
            end
            default: ;
         endcase
      end
   end

   // ---------------- FSM and stall counter --------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         count_reg <= '0;
      end else begin
         case (state_reg)
            RUN:     if (MulDiv_E) state_reg <= MC_WAIT;
            MC_WAIT: if (McDone)   state_reg <= RUN;
            default: state_reg <= RUN;
         endcase
         if (stall_f && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + CNT_W'(1);
         end
      end
   end

   assign StallF     = stall_f;
   assign StallD     = stall_d;
   assign StallE     = stall_e;
   assign FlushD     = flush_d;
   assign FlushE     = flush_e;
   assign FlushM     = flush_m;
   assign McStart    = mc_start;
   assign ForwardA_E = rst ? FWD_RF : fwd_a;
   assign ForwardB_E = rst ? FWD_RF : fwd_b;
   assign StallCount = count_reg;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  Rs1_D = '0, Rs2_D = '0, Rs1_E = '0, Rs2_E = '0;
   logic [4:0]  Rd_E = '0, Rd_M = '0, Rd_W = '0;
   logic        RegWrite_E = 1'b0, RegWrite_M = 1'b0, RegWrite_W = 1'b0;
   logic [1:0]  ResultSrc_E = '0;
   logic        PCSrc_E = 1'b0, MulDiv_E = 1'b0, McDone = 1'b0;
   logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, McStart;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic [31:0] StallCount;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   hazard_controller #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
      .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E), .McDone(McDone),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .McStart(McStart),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .StallCount(StallCount)
   );

   // {sf, sd, se, fd, fe, fm, mcs, fa, fb}
   typedef struct packed {
      logic       sf, sd, se, fd, fe, fm, mcs;
      logic [1:0] fa, fb;
   } out_t;

   // Reference model state: is a multi-cycle op occupying EX, expected count.
   bit              m_busy = 1'b0;
   longint unsigned m_count = 0;

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
`ifdef HAZARD_FWD_EN
      if (RegWrite_M && Rd_M == rs) return 2'b10;
      if (RegWrite_W && Rd_W == rs) return 2'b01;
`endif
      return 2'b00;
   endfunction

   // Does the instruction in decode have to wait for an older producer?
   function automatic bit m_d_wait();
      logic [4:0] rd [3];
      logic       we [3];
      bit         hit;
      rd = '{Rd_E, Rd_M, Rd_W};
      we = '{RegWrite_E, RegWrite_M, RegWrite_W};
      for (int p = 0; p < 3; p++) begin
         hit = (rd[p] != 5'd0) && (rd[p] == Rs1_D || rd[p] == Rs2_D);
`ifdef HAZARD_FWD_EN
         if (p == 0 && hit && ResultSrc_E == 2'b01) return 1'b1;
`else
         if (hit && we[p]) return 1'b1;
`endif
      end
      return 1'b0;
   endfunction

   function automatic out_t expect_now();
      out_t e;
      e = '0;
      if (rst) return e;
      e.fa = m_fwd(Rs1_E);
      e.fb = m_fwd(Rs2_E);
      if (m_busy) begin
         {e.sf, e.sd, e.se, e.fm} = {4{!McDone}};
      end else if (MulDiv_E) begin
         {e.sf, e.sd, e.se, e.fm, e.mcs} = 5'b11111;
      end else if (PCSrc_E) begin
         {e.fd, e.fe} = 2'b11;
      end else if (m_d_wait()) begin
         {e.sf, e.sd, e.fe} = 3'b111;
      end
      return e;
   endfunction

   function automatic out_t observed();
      return {StallF, StallD, StallE, FlushD, FlushE, FlushM, McStart, ForwardA_E, ForwardB_E};
   endfunction

   // Advance one clock and update the model from the inputs seen at the edge.
   task automatic step();
      out_t e;
      e = expect_now();
      @(posedge clk);
      if (rst) begin
         m_busy  = 1'b0;
         m_count = 0;
      end else begin
         if (m_busy) begin
            if (McDone) m_busy = 1'b0;
         end else if (MulDiv_E) begin
            m_busy = 1'b1;
         end
         if (e.sf && m_count < 64'hFFFF_FFFF) m_count++;
      end
      #1;
      cyc++;
   endtask

   task automatic idle();
      {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
      {RegWrite_E, RegWrite_M, RegWrite_W, PCSrc_E, MulDiv_E, McDone} = '0;
      ResultSrc_E = 2'b00;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      out_t o;
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      m_busy = 1'b0;
      m_count = 0;
      for (int i = 0; i < 4; i++) begin
         Rs1_D = 5'd1; Rs2_D = 5'd2; Rs1_E = 5'd1; Rs2_E = 5'd2;
         Rd_E = 5'd1; Rd_M = 5'd1; Rd_W = 5'd2;
         {RegWrite_E, RegWrite_M, RegWrite_W} = 3'b111;
         ResultSrc_E = 2'b01;
         PCSrc_E = i[0]; MulDiv_E = i[1]; McDone = 1'b0;
         #4;
         o = observed();
         checks++;
         if (o !== '0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got=%b want=%b", cyc, o, 11'b0);
         end
         checks++;
         if (StallCount !== 32'd0) begin
            failures++;
            $display("FAIL reset_count cyc=%0d got=%0d want=0", cyc, StallCount);
         end
         step();
      end
      rst = 1'b0;
      idle();
      #4;
      o = observed();
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL reset_release cyc=%0d got=%b want=%b", cyc, o, 11'b0);
      end
      step();
      $display("test_reset done cyc=%0d", cyc);
   endtask

   task automatic test_load_use();
      out_t o, e;
      logic second_stall;
`ifdef HAZARD_FWD_EN
      second_stall = 1'b0;
`else
      second_stall = 1'b1;
`endif
      do_reset();
      ResultSrc_E = 2'b01; Rd_E = 5'd5; RegWrite_E = 1'b1; Rs1_D = 5'd5; Rs2_D = 5'd9;
      #4;
      o = observed(); e = expect_now();
      checks++;
      if (o !== e || {StallF, StallD, FlushE} !== 3'b111 || StallCount !== 32'd0) begin
         failures++;
         $display("FAIL load_use_hit cyc=%0d got=%b cnt=%0d want=%b cnt=0", cyc, o, StallCount, e);
      end
      step();
      // load moves to MEM, bubble in EX
      ResultSrc_E = 2'b00; Rd_E = 5'd0; RegWrite_E = 1'b0; Rd_M = 5'd5; RegWrite_M = 1'b1;
      #4;
      o = observed(); e = expect_now();
      checks++;
      if (o !== e || StallF !== second_stall || StallCount !== 32'd1) begin
         failures++;
         $display("FAIL load_use_after cyc=%0d got=%b sf=%b cnt=%0d want=%b sf=%b cnt=1",
                  cyc, o, StallF, StallCount, e, second_stall);
      end
      step();
      $display("test_load_use done cyc=%0d", cyc);
   endtask

   task automatic test_forward_priority();
      logic [1:0] want [3];
`ifdef HAZARD_FWD_EN
      want = '{2'b10, 2'b01, 2'b00};
`else
      want = '{2'b00, 2'b00, 2'b00};
`endif
      do_reset();
      Rd_M = 5'd7; Rd_W = 5'd7; RegWrite_M = 1'b1; RegWrite_W = 1'b1;
      Rs2_E = 5'd7; Rs1_E = 5'd1;
      for (int j = 0; j < 3; j++) begin
         if (j == 1) RegWrite_M = 1'b0;
         if (j == 2) Rs2_E = 5'd0;
         #4;
         checks++;
         if (ForwardB_E !== want[j] || observed() !== expect_now()) begin
            failures++;
            $display("FAIL fwd_priority_%0d cyc=%0d got=%b want=%b", j, cyc, ForwardB_E, want[j]);
         end
         step();
      end
      $display("test_forward_priority done cyc=%0d", cyc);
   endtask

   task automatic test_branch();
      out_t o, e;
      do_reset();
      ResultSrc_E = 2'b01; Rd_E = 5'd4; RegWrite_E = 1'b1; Rs2_D = 5'd4; PCSrc_E = 1'b1;
      #4;
      o = observed(); e = expect_now();
      checks++;
      if (o !== e || {FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
         failures++;
         $display("FAIL branch_flush cyc=%0d got=%b want=%b", cyc, o, e);
      end
      step();
      idle();
      #4;
      checks++;
      if (StallCount !== 32'd0) begin
         failures++;
         $display("FAIL branch_count cyc=%0d got=%0d want=0", cyc, StallCount);
      end
      step();
      $display("test_branch done cyc=%0d", cyc);
   endtask

   task automatic test_multicycle();
      out_t o, e;
      do_reset();
      MulDiv_E = 1'b1;
      for (int k = 0; k < 5; k++) begin
         McDone = (k == 4);
         #4;
         o = observed(); e = expect_now();
         checks++;
         if (o !== e || McStart !== (k == 0) || StallE !== (k < 4) || FlushM !== (k < 4)) begin
            failures++;
            $display("FAIL mc_seq_%0d cyc=%0d got=%b want=%b", k, cyc, o, e);
         end
         step();
      end
      idle();
      #4;
      o = observed();
      checks++;
      if (o !== '0 || StallCount !== 32'd4) begin
         failures++;
         $display("FAIL mc_after cyc=%0d got=%b cnt=%0d want=%b cnt=4", cyc, o, StallCount, 11'b0);
      end
      McDone = 1'b1;   // stray done in RUN must not change anything
      #1;
      checks++;
      if (observed() !== '0) begin
         failures++;
         $display("FAIL mc_stray_done cyc=%0d got=%b want=%b", cyc, observed(), 11'b0);
      end
      step();
      McDone = 1'b0; MulDiv_E = 1'b1;
      #4;
      checks++;
      if (McStart !== 1'b1 || observed() !== expect_now()) begin
         failures++;
         $display("FAIL mc_restart cyc=%0d got=%b want=1", cyc, McStart);
      end
      step();
      McDone = 1'b1;
      #4;
      checks++;
      if (McStart !== 1'b0 || StallF !== 1'b0 || observed() !== expect_now()) begin
         failures++;
         $display("FAIL mc_quick_done cyc=%0d got=%b want=%b", cyc, observed(), expect_now());
      end
      step();
      idle();
      step();
      $display("test_multicycle done cyc=%0d", cyc);
   endtask

   task automatic test_reset_mid_op();
      out_t o;
      do_reset();
      MulDiv_E = 1'b1;
      step();          // start
      step();          // first MC_WAIT cycle
      rst = 1'b1;      // two cycles into MC_WAIT
      #4;
      o = observed();
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL midop_rst_outputs cyc=%0d got=%b want=%b", cyc, o, 11'b0);
      end
      step();
      rst = 1'b0;
      MulDiv_E = 1'b0;
      McDone = 1'b0;
      #4;
      o = observed();
      checks++;
      if (o !== '0 || StallCount !== 32'd0) begin
         failures++;
         $display("FAIL midop_run cyc=%0d got=%b cnt=%0d want=%b cnt=0", cyc, o, StallCount, 11'b0);
      end
      step();
      $display("test_reset_mid_op done cyc=%0d", cyc);
   endtask

   task automatic test_raw_stall();
      logic       want_sf [3];
      logic [1:0] want_fa [3];
`ifdef HAZARD_FWD_EN
      want_sf = '{1'b0, 1'b0, 1'b0};
      want_fa = '{2'b10, 2'b01, 2'b00};
`else
      want_sf = '{1'b1, 1'b1, 1'b0};
      want_fa = '{2'b00, 2'b00, 2'b00};
`endif
      do_reset();
      Rd_M = 5'd3; RegWrite_M = 1'b1; Rs1_D = 5'd3; Rs1_E = 5'd3;
      for (int j = 0; j < 3; j++) begin
         if (j == 1) begin Rd_M = 5'd0; RegWrite_M = 1'b0; Rd_W = 5'd3; RegWrite_W = 1'b1; end
         if (j == 2) begin Rd_W = 5'd0; RegWrite_W = 1'b0; end
         #4;
         checks++;
         if (StallF !== want_sf[j] || ForwardA_E !== want_fa[j] || observed() !== expect_now()) begin
            failures++;
            $display("FAIL raw_stall_%0d cyc=%0d got sf=%b fa=%b want sf=%b fa=%b",
                     j, cyc, StallF, ForwardA_E, want_sf[j], want_fa[j]);
         end
         step();
      end
      $display("test_raw_stall done cyc=%0d", cyc);
   endtask

   task automatic test_x0();
      out_t o;
      do_reset();
      ResultSrc_E = 2'b01; RegWrite_E = 1'b1; RegWrite_M = 1'b1; RegWrite_W = 1'b1;
      #4;
      o = observed();
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL x0_no_hazard cyc=%0d got=%b want=%b", cyc, o, 11'b0);
      end
      step();
      $display("test_x0 done cyc=%0d", cyc);
   endtask

   task automatic test_random();
      out_t o, e;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
         Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
         Rd_E  = 5'($urandom_range(0, 3)); Rd_M  = 5'($urandom_range(0, 3));
         Rd_W  = 5'($urandom_range(0, 3));
         RegWrite_E = 1'($urandom); RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
         ResultSrc_E = 2'($urandom_range(0, 2));
         PCSrc_E = ($urandom_range(0, 5) == 0);
         MulDiv_E = m_busy ? 1'b1 : ($urandom_range(0, 7) == 0);
         McDone = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         #4;
         o = observed(); e = expect_now();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL random_outputs cyc=%0d got=%b want=%b", cyc, o, e);
         end
         checks++;
         if (StallCount !== m_count[31:0]) begin
            failures++;
            $display("FAIL random_count cyc=%0d got=%0d want=%0d", cyc, StallCount, m_count);
         end
         step();
      end
      rst = 1'b0;
      idle();
      $display("test_random done cyc=%0d", cyc);
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_forward_priority();
      test_branch();
      test_multicycle();
      test_reset_mid_op();
      test_raw_stall();
      test_x0();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage RV64I/Zba core. It sits beside the decode and execute stages and drives stall and flush enables for the IF/ID, ID/EX and EX/MEM registers. It resolves load-use and branch/jump hazards, selects operand forwarding paths, and sequences a long-latency execute unit with a start/done handshake. It also keeps a saturating count of stall cycles for performance monitoring.

## Interface
- CNT_W, 32, width of stall-cycle counter
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- Rs1_D, Rs2_D  in  5  source register addresses in decode
- Rs1_E, Rs2_E  in  5  source register addresses in execute
- Rd_E, Rd_M, Rd_W  in  5  destination addresses in EX/MEM/WB
- RegWrite_E, RegWrite_M, RegWrite_W  in  1  write enables per stage
- ResultSrc_E  in  2  result select in execute (2'b01 = load)
- PCSrc_E  in  1  branch taken or jump resolved in execute
- MulDiv_E  in  1  execute-stage instruction needs the multi-cycle unit
- McDone  in  1  single-cycle pulse from the multi-cycle unit: result valid
- StallF, StallD, StallE  out  1  hold PC, IF/ID, ID/EX
- FlushD, FlushE, FlushM  out  1  bubble into IF/ID, ID/EX, EX/MEM
- McStart  out  1  single-cycle start pulse to the multi-cycle unit
- ForwardA_E, ForwardB_E  out  2  operand source: 00 RF, 10 MEM result, 01 WB result
- StallCount  out  CNT_W  stall-cycle count

## Operation
- FSM states: RUN, MC_WAIT.
- RUN:
  - If MulDiv_E=1: assert McStart, StallF/StallD/StallE=1, FlushM=1, and go to MC_WAIT.
  - Else apply the hazard rules below.
- MC_WAIT:
  - StallF/StallD/StallE = FlushM = !McDone.
  - On McDone=1, all four are 0 that cycle, the instruction advances, and the FSM returns to RUN.
  - McStart=0 throughout.
  - PCSrc_E and load-use are ignored; neither can occur while E holds a multi-cycle op.
- Load-use, RUN only:
  - Condition: ResultSrc_E=01 and Rd_E!=0 and (Rd_E==Rs1_D or Rd_E==Rs2_D).
  - Response: StallF=StallD=1 and FlushE=1 for one cycle.
- Control hazard: PCSrc_E=1 gives FlushD=FlushE=1. Flush takes priority over any stall on the same register.
- Forwarding, per operand X∈{A,B}, with Rs=Rs1_E/Rs2_E:
  - 10 if RegWrite_M and Rd_M!=0 and Rd_M==Rs.
  - Else 01 if RegWrite_W and Rd_W!=0 and Rd_W==Rs.
  - Else 00. MEM has priority over WB.
- Register x0 never creates a hazard or a forward.
- StallCount increments every cycle StallF=1 and saturates at all-ones.

## Timing
- Reset values: FSM=RUN, StallCount=0, McStart=0.
- While rst=1, all stall/flush outputs are 0 and forwards are 00.
- Stall, flush and forward outputs are combinational from inputs and current state; only the FSM and counter are registered.
- McStart is high exactly one cycle per multi-cycle instruction.
- Earliest McDone is the cycle after McStart. An McDone in RUN is ignored.
- Reset asserted during MC_WAIT returns the FSM to RUN next edge. The multi-cycle unit is reset separately.
- Load-use adds 1 bubble. A taken branch costs 2 slots. A multi-cycle op holds E for N+1 cycles, where McDone arrives N cycles after McStart.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- HAZARD_FWD_EN undefined:
  - ForwardA_E/ForwardB_E are tied to 00.
  - Any RAW match of Rs1_D/Rs2_D against Rd_E/Rd_M/Rd_W (with RegWrite set and Rd!=0) asserts StallF=StallD=1 and FlushE=1, repeating until clear.
  - The load-use rule is subsumed.

## Structure
- Shared package holds:
  - the FSM state enum
  - the forward-select encodings FWD_RF/FWD_MEM/FWD_WB
  - the ResultSrc encodings RES_ALU=00, RES_MEM=01, RES_PC4=10
- One sub-module, hazard_forward_sel: combinational comparison for a single operand, instantiated twice.

## Test plan
- Load-use: load with Rd_E=5 in E, Rs1_D=5 in D → StallF=StallD=FlushE=1 for exactly one cycle; StallCount 0→1.
- Forward priority: Rd_M=Rd_W=7, both RegWrite, Rs2_E=7 → ForwardB_E=10. Drop RegWrite_M → ForwardB_E=01. Set Rs2_E=0 → ForwardB_E=00.
- Branch: PCSrc_E=1 while a load-use condition is also present in D → FlushD=FlushE=1, StallF=0.
- Multi-cycle: MulDiv_E=1, McDone 4 cycles after McStart → McStart one pulse, StallE/FlushM high 4 cycles, low on the McDone cycle, FSM back in RUN.
- Reset mid-op: rst asserted 2 cycles into MC_WAIT → next cycle RUN, all outputs 0, StallCount=0.
- With HAZARD_FWD_EN undefined: ALU op writing x3 in M with Rs1_D=3 → stall until the writer leaves WB; forwards stay 00.
